// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icodes, register IDs, status codes and control FSM states
package y86_pkg;
    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;
    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: raw load-use, pending-ret and branch-mispredict detection
module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] E_icode,
    input  logic [3:0] M_icode,
    input  logic [3:0] E_dstM,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic       M_Cnd,
    output logic       load_use,
    output logic       ret_pend,
    output logic       mispredict
);
    assign mispredict = M_icode == JXX && !M_Cnd;
    assign ret_pend   = D_icode == RET || E_icode == RET || M_icode == RET;
    assign load_use   = (E_icode == MRMOVQ || E_icode == POPQ) && E_dstM != RNONE &&
                        (E_dstM == d_srcA || E_dstM == d_srcB);
endmodule

// File: rtl/pipe_pc_ctrl.sv
// pipe_pc_ctrl: PC select, pipeline stall/bubble control and halt drain FSM (perf counters under PIPE_PC_CTRL_PERF_EN)
module pipe_pc_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'd0,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  f_icode,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        f_instr_valid,
    input  logic        f_imem_error,
    input  logic        f_hlt,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  W_icode,
    input  logic [3:0]  E_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [63:0] W_valM,
    output logic [63:0] pc,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic [2:0]  stat
`ifdef PIPE_PC_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt
`endif
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    state_t        state;
    logic [63:0]   pred_pc;
    logic [CW-1:0] drain_cnt;
    logic [2:0]    cause;
    logic          load_use_raw, ret_pend_raw, mispredict_raw;
    logic          active, lu, rp, mp, wr, halt_req;
    logic [2:0]    halt_cause;

    pipe_hazard_detect u_hazard (
        .D_icode    (D_icode),
        .E_icode    (E_icode),
        .M_icode    (M_icode),
        .E_dstM     (E_dstM),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .M_Cnd      (M_Cnd),
        .load_use   (load_use_raw),
        .ret_pend   (ret_pend_raw),
        .mispredict (mispredict_raw)
    );

    // Hazards are ignored while reset is held and once halted, so controls and pc stay still
    assign active     = !reset && state != HALTED;
    assign lu         = active && load_use_raw;
    assign rp         = active && ret_pend_raw;
    assign mp         = active && mispredict_raw;
    assign wr         = active && W_icode == RET;
    assign pc         = mp ? M_valA : wr ? W_valM : pred_pc;
    assign F_stall    = !reset && (lu || rp || state != RUN);
    assign D_stall    = lu;
    assign D_bubble   = mp || (rp && !lu);
    assign E_bubble   = mp || lu;
    assign halt_req   = f_hlt || f_imem_error || !f_instr_valid;
    assign halt_cause = f_imem_error ? ADR : !f_instr_valid ? INS : HLT;

    // Predicted PC, drain sequencing and status; a redirect during drain cancels the halt
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            pred_pc   <= RESET_PC;
            drain_cnt <= '0;
            cause     <= AOK;
            stat      <= AOK;
        end else begin
            case (state)
                RUN: begin
                    if (!F_stall)
                        pred_pc <= (f_icode == JXX || f_icode == CALL) ? f_valC : f_valP;
                    if (halt_req && !mp) begin
                        state     <= DRAIN;
                        cause     <= halt_cause;
                        drain_cnt <= CW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (mp || wr) begin
                        state     <= RUN;
                        cause     <= AOK;
                        drain_cnt <= '0;
                        pred_pc   <= mp ? M_valA : W_valM;
                    end else if (drain_cnt == CW'(1)) begin
                        state     <= HALTED;
                        stat      <= cause;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_PC_CTRL_PERF_EN
    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (state != HALTED && !(&cyc_cnt))
                cyc_cnt <= cyc_cnt + 32'd1;
            if (state == RUN && F_stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// tb_pipe_pc_ctrl: directed test-plan walk plus randomized run against a behavioural model
module tb_pipe_pc_ctrl;
    logic        clk = 0;
    logic        reset;
    logic [3:0]  f_icode, D_icode, E_icode, M_icode, W_icode, E_dstM, d_srcA, d_srcB;
    logic [63:0] f_valC, f_valP, M_valA, W_valM, pc;
    logic        f_instr_valid, f_imem_error, f_hlt, M_Cnd;
    logic        F_stall, D_stall, D_bubble, E_bubble;
    logic [2:0]  stat;

    int checks = 0;
    int failures = 0;

    logic [63:0] m_pred;
    int          m_mode;
    int          m_cnt;
    logic [2:0]  m_cause, m_stat;
    bit          t_mis, t_wret, t_lu, t_rp, t_fs;
    logic [63:0] held;

    pipe_pc_ctrl dut (
        .clk(clk), .reset(reset), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
        .f_instr_valid(f_instr_valid), .f_imem_error(f_imem_error), .f_hlt(f_hlt),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .M_Cnd(M_Cnd),
        .M_valA(M_valA), .W_valM(W_valM), .pc(pc), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .stat(stat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 0; f_icode = 4'h1; f_valC = 64'h0; f_valP = 64'h100;
        f_instr_valid = 1; f_imem_error = 0; f_hlt = 0;
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF; M_Cnd = 1; M_valA = 64'h0; W_valM = 64'h0;
    endtask

    // mode: 0 running, 1 draining, 2 halted
    task automatic model_check();
        bit act;
        #1;
        act    = !reset && m_mode != 2;
        t_mis  = act && M_icode == 4'h7 && !M_Cnd;
        t_wret = act && W_icode == 4'h9;
        t_lu   = act && (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
                 (E_dstM == d_srcA || E_dstM == d_srcB);
        t_rp   = act && (D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9);
        t_fs   = !reset && (t_lu || t_rp || m_mode != 0);
        chk("pc", pc, t_mis ? M_valA : t_wret ? W_valM : m_pred);
        chk("F_stall", 64'(F_stall), 64'(t_fs));
        chk("D_stall", 64'(D_stall), 64'(t_lu));
        chk("D_bubble", 64'(D_bubble), 64'(t_mis || (t_rp && !t_lu)));
        chk("E_bubble", 64'(E_bubble), 64'(t_mis || t_lu));
        chk("stat", 64'(stat), 64'(m_stat));
    endtask

    task automatic tick();
        if (reset) begin
            m_pred = 64'h0; m_mode = 0; m_cnt = 0; m_cause = 3'd1; m_stat = 3'd1;
        end else if (m_mode == 0) begin
            if (!t_fs) m_pred = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valC : f_valP;
            if ((f_hlt || f_imem_error || !f_instr_valid) && !t_mis) begin
                m_mode = 1; m_cnt = 4;
                m_cause = f_imem_error ? 3'd3 : !f_instr_valid ? 3'd4 : 3'd2;
            end
        end else if (m_mode == 1) begin
            if (t_mis || t_wret) begin
                m_mode = 0; m_cause = 3'd1; m_pred = t_mis ? M_valA : W_valM;
            end else if (m_cnt == 1) begin
                m_mode = 2; m_stat = m_cause;
            end else m_cnt--;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle(); reset = 1;
        tick();
        model_check();
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_fstall", 64'(F_stall), 64'd0);
        tick();
        // fall-through
        idle(); f_icode = 4'h3; f_valP = 64'd10;
        model_check(); chk("tp_pc0", pc, 64'd0); tick();
        idle(); model_check(); chk("tp_pc10", pc, 64'd10); chk("tp_stat", 64'(stat), 64'd1); tick();
        // call target, then mispredict
        idle(); f_icode = 4'h8; f_valC = 64'h2D; model_check(); tick();
        idle(); model_check(); chk("call_pc", pc, 64'h2D); tick();
        idle(); M_icode = 4'h7; M_Cnd = 0; M_valA = 64'h21;
        model_check(); chk("mis_pc", pc, 64'h21);
        chk("mis_dbub", 64'(D_bubble), 64'd1); chk("mis_ebub", 64'(E_bubble), 64'd1); tick();
        // load-use
        idle(); E_icode = 4'h5; E_dstM = 4'd1; d_srcA = 4'd1; f_valP = 64'h55;
        model_check(); held = pc;
        chk("lu_fstall", 64'(F_stall), 64'd1); chk("lu_dstall", 64'(D_stall), 64'd1);
        chk("lu_ebub", 64'(E_bubble), 64'd1); chk("lu_dbub", 64'(D_bubble), 64'd0); tick();
        idle(); model_check(); chk("lu_pc_hold", pc, held); tick();
        // ret walking D, E, M then W
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 0) D_icode = 4'h9; else if (i == 1) E_icode = 4'h9; else M_icode = 4'h9;
            model_check(); chk("ret_fstall", 64'(F_stall), 64'd1); chk("ret_dbub", 64'(D_bubble), 64'd1); tick();
        end
        idle(); W_icode = 4'h9; W_valM = 64'h20; model_check(); chk("ret_pc", pc, 64'h20); tick();
        // halt drain
        idle(); f_icode = 4'h7; f_valC = 64'h21; model_check(); tick();
        idle(); f_hlt = 1; f_valP = 64'h22; model_check(); chk("hlt_pc", pc, 64'h21); tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            model_check(); chk("drain_stat", 64'(stat), 64'd1); chk("drain_pc", pc, 64'h22); tick();
        end
        for (int i = 0; i < 3; i++) begin
            idle(); M_icode = 4'h7; M_Cnd = 0; M_valA = 64'h99; W_icode = 4'h9; W_valM = 64'h77;
            model_check(); chk("halted_stat", 64'(stat), 64'd2); chk("halted_pc", pc, 64'h22);
            chk("halted_fstall", 64'(F_stall), 64'd1); tick();
        end
        idle(); reset = 1; model_check(); tick();
        idle(); model_check(); chk("rerst_stat", 64'(stat), 64'd1); chk("rerst_pc", pc, 64'd0); tick();
        // halt cancelled by mispredict
        idle(); f_hlt = 1; model_check(); tick();
        idle(); M_icode = 4'h7; M_Cnd = 0; M_valA = 64'h40; model_check(); chk("cancel_pc", pc, 64'h40); tick();
        idle(); model_check(); chk("cancel_pc2", pc, 64'h40); chk("cancel_fstall", 64'(F_stall), 64'd0); tick();
        for (int i = 0; i < 5; i++) begin
            idle(); model_check(); chk("cancel_stat", 64'(stat), 64'd1); tick();
        end
        // address error wins over invalid and halt
        idle(); f_imem_error = 1; f_instr_valid = 0; f_hlt = 1; model_check(); tick();
        idle();
        for (int i = 0; i < 4; i++) begin model_check(); tick(); end
        model_check(); chk("adr_stat", 64'(stat), 64'd3);
        idle(); reset = 1; tick();
        // randomized run
        for (int n = 0; n < 3000; n++) begin
            reset         = $urandom_range(0, 99) == 0;
            f_icode       = 4'($urandom_range(0, 11));
            f_valC        = {$urandom, $urandom};
            f_valP        = {$urandom, $urandom};
            f_instr_valid = $urandom_range(0, 15) != 0;
            f_imem_error  = $urandom_range(0, 15) == 0;
            f_hlt         = $urandom_range(0, 7) == 0;
            D_icode       = ($urandom_range(0, 7) == 0) ? 4'h9 : 4'($urandom_range(0, 11));
            E_icode       = ($urandom_range(0, 3) == 0) ? 4'h5 : 4'($urandom_range(0, 11));
            M_icode       = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 11));
            W_icode       = ($urandom_range(0, 9) == 0) ? 4'h9 : 4'($urandom_range(0, 8));
            E_dstM        = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            d_srcA        = 4'($urandom_range(0, 7));
            d_srcB        = 4'($urandom_range(0, 15));
            M_Cnd         = 1'($urandom_range(0, 1));
            M_valA        = {$urandom, $urandom};
            W_valM        = {$urandom, $urandom};
            model_check();
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_pc_ctrl.md
Name: pipe_pc_ctrl

Overview:
- PC-select and pipeline-control unit for the 5-stage Y86-64 pipeline.
- Holds the predicted-PC register and drives the PC into the fetch stage.
- Detects load-use, mispredict and ret hazards, and issues stall/bubble controls to the F/D/E pipeline registers.
- Sequences halt/exception drain through a small state machine and reports processor status.

Parameters:
- RESET_PC, 64'd0, value loaded into predPC on reset.
- DRAIN_CYCLES, 4, cycles from halt detection at fetch until HALTED (D, E, M, W stages).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- f_icode  in  4  icode decoded by fetch this cycle.
- f_valC  in  64  constant word from fetch.
- f_valP  in  64  fall-through PC from fetch.
- f_instr_valid  in  1  fetch reports legal icode.
- f_imem_error  in  1  fetch reports address out of range.
- f_hlt  in  1  fetch decoded halt.
- D_icode, E_icode, M_icode, W_icode  in  4 each  icodes in the pipeline registers.
- E_dstM  in  4  load destination in E.
- d_srcA, d_srcB  in  4 each  decode source registers.
- M_Cnd  in  1  branch condition for the jXX in M.
- M_valA  in  64  fall-through PC carried by the jXX in M.
- W_valM  in  64  return address popped by the ret in W.
- pc  out  64  address presented to fetch.
- F_stall, D_stall, D_bubble, E_bubble  out  1 each  pipeline-register controls.
- stat  out  3  processor status: AOK=1, HLT=2, ADR=3, INS=4.

Behaviour:
- Reset: predPC=RESET_PC, state=RUN, drain_cnt=0, stat=AOK, all stall/bubble outputs 0.
- pc is combinational, evaluated in priority order:
  - mispredict (M_icode==JXX && !M_Cnd) -> M_valA;
  - else W_icode==RET -> W_valM;
  - else predPC.
- predPC update on posedge when !F_stall and state==RUN:
  - f_icode in {JXX, CALL} -> f_valC;
  - else f_valP.
  - All adds are 64-bit with wrap-around and no flags.
- load_use = E_icode in {MRMOVQ, POPQ} && E_dstM!=RNONE && E_dstM in {d_srcA, d_srcB}.
- ret_pend = RET in any of D_icode, E_icode, M_icode.
- Control equations:
  - F_stall = load_use | ret_pend | (state!=RUN).
  - D_stall = load_use.
  - D_bubble = mispredict | (ret_pend & !load_use).
  - E_bubble = mispredict | load_use.
  - Simultaneous load_use and ret in E: the stall wins and D is not bubbled.
- FSM states RUN, DRAIN, HALTED:
  - RUN -> DRAIN when f_hlt | f_imem_error | !f_instr_valid, and not mispredict that cycle. Latch the cause code (HLT, ADR or INS; priority ADR > INS > HLT) and set drain_cnt=DRAIN_CYCLES.
  - DRAIN: drain_cnt decrements each cycle and predPC is frozen.
    - A mispredict in DRAIN means the halting instruction was on the wrong path: return to RUN, clear the cause, and load predPC from M_valA.
    - A ret reaching W in DRAIN is handled the same way, with predPC loaded from W_valM.
    - drain_cnt==1 and no cancel -> HALTED; stat=latched cause.
  - HALTED: absorbing; all outputs hold; only reset exits.
- Reset asserted mid-DRAIN or in HALTED returns to the reset values on the next edge.

Optional Feature:
- Macro PIPE_PC_CTRL_PERF_EN.
- When defined:
  - Add outputs cyc_cnt[31:0] and stall_cnt[31:0], both cleared on reset.
  - cyc_cnt increments each cycle state!=HALTED.
  - stall_cnt increments each cycle F_stall is asserted in RUN.
  - Both counters saturate at all-ones.
- When undefined: the ports and counters are absent, with no functional change.

Decomposition:
- Shared package y86_pkg:
  - icode constants HALT..POPQ (0..B);
  - RNONE=4'hF;
  - stat codes AOK/HLT/ADR/INS;
  - FSM state typedef.
- One natural combinational sub-module, pipe_hazard_detect: computes load_use, ret_pend and mispredict from the stage icodes and register IDs. pipe_pc_ctrl instantiates it and owns predPC, the FSM and the counters.

Test Plan:
- Reset, then f_icode=IRMOVQ, f_valP=10 -> pc=0 in cycle 0; next cycle pc=10, stat=1.
- f_icode=CALL, f_valC=0x2D -> next pc=0x2D; then M_icode=JXX, M_Cnd=0, M_valA=0x21 -> same-cycle pc=0x21 and D_bubble=E_bubble=1.
- E_icode=MRMOVQ, E_dstM=1, d_srcA=1 -> F_stall=D_stall=E_bubble=1 and D_bubble=0; pc unchanged for one cycle.
- D_icode=RET, advancing through E and M:
  - expect 3 cycles of F_stall=1 and D_bubble=1;
  - W_icode=RET with W_valM=0x20 -> pc=0x20.
- f_hlt=1 at pc=0x21:
  - 4 cycles in DRAIN, then stat=2;
  - pc frozen and outputs stable thereafter;
  - reset -> stat=1, pc=0.
- f_hlt=1, then M_icode=JXX, M_Cnd=0 one cycle later -> FSM returns to RUN, stat stays 1, pc=M_valA. Separately, f_imem_error=1 -> stat=3.
